hazard_mc_ctrl: RTL
===================

Name: hazard_mc_ctrl

Overview:
Parametrised next-generation hazard unit for the 5-stage MIPS pipeline.
- Keeps the existing combinational duties: GPR forwarding, load-use and branch stalls, HI/LO forwarding.
- Adds a sequenced multi-cycle unit (MUL/DIV) handshake FSM with a one-shot start, a cancel path and a watchdog.
- Adds an external memory stall input and an exception flush input.
- Sits beside the datapath and drives all stall/flush/forward selects.

Parameters:
REG_AW, 5, register address width
MD_TIMEOUT, 64, max cycles to wait for md_ready before watchdog fires (≥2)
BR_RESOLVE_D, 1, 1 = branches resolve in D (D-stage forwarding/branch stall active); 0 = resolve in E (forwardaD/forwardbD tied 0, branch stall disabled, flushD on taken branch instead)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
rsD, rtD, rsE, rtE  in  REG_AW  source regs in D/E
writeregE, writeregM, writeregW  in  REG_AW  destination regs
regwriteE, regwriteM, regwriteW  in  1  GPR write enables
memtoregE, memtoregM  in  1  load in stage
branchD, jrD, balD, jumpD  in  1  control-flow decode
branch_takenE  in  1  taken branch in E (used only when BR_RESOLVE_D=0)
hilo_weE, hilo_weM, hilo_weW  in  2  HI/LO write enables
mdE  in  2  multi-cycle op in E: 00 none, 01 mul, 10 div, 11 reserved (treated as none)
md_ready  in  1  result valid from MUL/DIV unit
ext_stall  in  1  memory/cache stall, freezes whole pipe
flush_exc  in  1  exception flush
stallF, stallD, stallE, stallM  out  1  stage holds
flushD, flushE, flushM  out  1  stage bubbles
forwardaE, forwardbE  out  2  00 RF, 10 M, 01 W
forwardaD, forwardbD  out  1  M→D forward
forwardhiloE  out  2  00 none, 01 M, 10 W
md_start  out  1  one-cycle start pulse
md_cancel  out  1  one-cycle abort pulse
md_busy  out  1  FSM not IDLE
md_timeout  out  1  sticky watchdog error

Behaviour:
- Reset (rst=0, async): FSM=IDLE, counter=0, md_timeout=0. All registered outputs 0. Combinational outputs follow their inputs.
- Forwarding (combinational):
  - Reg 0 is never forwarded.
  - M has priority over W.
  - forwardhiloE = 01 if hilo_weE==0 and hilo_weM≠0, else 10 if hilo_weE==0 and hilo_weW≠0, else 00.
- lwstall = memtoregE & regwriteE & writeregE≠0 & (rsD==writeregE | rtD==writeregE).
- branchstall (BR_RESOLVE_D=1 only): either
  - (branchD|jrD|balD) & regwriteE & writeregE≠0 & writeregE∈{rsD,rtD}, or
  - (branchD|jrD) & memtoregM & writeregM∈{rsD,rtD}.
- FSM states IDLE, RUN, DONE:
  - IDLE → RUN when mdE≠0 & !flush_exc & !md_timeout. md_start=1 that cycle only; counter cleared.
  - RUN: counter increments each cycle. md_ready → DONE. Counter reaching MD_TIMEOUT-1 → IDLE, md_timeout set (sticky until reset), md_cancel pulse.
  - DONE: stays while ext_stall=1, so the result is held. → IDLE when ext_stall=0 (E advances that cycle).
  - Any state with flush_exc=1 → IDLE. md_cancel pulses for one cycle if the state was RUN. flush_exc has priority over md_ready in the same cycle.
- md_wait = (state==IDLE & mdE≠0 & !md_timeout) | state==RUN.
- Stall/flush equations:
  - stallE = md_wait | ext_stall.
  - stallM = ext_stall.
  - stallF = stallD = lwstall | branchstall | stallE.
  - flushE = (lwstall | branchstall | jumpD | (branchD & !balD)) & !stallE, or flush_exc.
  - flushM = md_wait & !ext_stall, or flush_exc. This bubbles M while E is held.
  - flushD = flush_exc | (BR_RESOLVE_D=0 & branch_takenE & !stallE).
  - flush_exc overrides all stalls: every stall output is 0 while flush_exc=1.
- Simultaneous md_ready and ext_stall in RUN → DONE, stallE stays 1.

Decomposition:
- Shared package/defines holds:
  - MD op encodings (MD_NONE/MUL/DIV).
  - Forward select codes (FWD_RF/FWD_M/FWD_W, HILO_FWD_*).
  - FSM state encodings.
- One sub-module, md_seq_fsm: FSM, counter, md_start/md_cancel/md_timeout, md_wait.
- Top module keeps the combinational hazard logic.

Test Plan:
1. Load-use: memtoregE=1, regwriteE=1, writeregE=8, rsD=8 → stallF=stallD=1, flushE=1 for one cycle, then forwardaE=01 next cycle.
2. DIV, md_ready after 5 cycles: mdE=10 → md_start high exactly 1 cycle; stallE=1 for 6 cycles; flushM=1 while waiting; md_busy drops after DONE→IDLE.
3. DIV done under ext_stall: md_ready at cycle 3 with ext_stall=1 for cycles 3–6 → state DONE through cycle 6; stallE=1 throughout; no second md_start.
4. flush_exc in RUN at cycle 2 → md_cancel=1 one cycle, FSM IDLE, all stalls 0, flushD=flushE=flushM=1.
5. Watchdog, MD_TIMEOUT=8, md_ready never → md_timeout=1 at cycle 8, md_cancel pulse, stalls release; a later mdE=10 produces no md_start.
6. Forward priority: writeregM=writeregW=rtE=5, both regwrite=1 → forwardbE=10. With rtE=0 → 00. hilo_weE=0, hilo_weM=11 → forwardhiloE=01.

Source files
------------

// File: rtl/hazard_mc_ctrl_pkg.sv
// Shared encodings for the hazard unit and its multi-cycle sequencer.
// Op codes, forward selects and sequencer state values.
package hazard_mc_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] HILO_FWD_NONE = 2'b00;
  localparam logic [1:0] HILO_FWD_M    = 2'b01;
  localparam logic [1:0] HILO_FWD_W    = 2'b10;

  // Encoding 11 is reserved and behaves like no operation.
  function automatic logic md_is_op(input logic [1:0] op);
    return (op == MD_MUL) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_seq_fsm.sv
// Multi-cycle MUL/DIV handshake sequencer.
// One-shot start, cancel on flush or watchdog, sticky timeout.
module md_seq_fsm
  import hazard_mc_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] md_op_i,
  input  logic       md_ready_i,
  input  logic       ext_stall_i,
  input  logic       flush_exc_i,
  output logic       md_start_o,
  output logic       md_cancel_o,
  output logic       md_busy_o,
  output logic       md_timeout_o,
  output logic       md_wait_o
);

  localparam int CW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MD_TIMEOUT - 1);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  logic          op_v;

  assign op_v = md_is_op(md_op_i);

  // State, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // Next state and start/cancel pulses; flush beats md_ready.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    to_d        = to_q;
    md_start_o  = 1'b0;
    md_cancel_o = 1'b0;
    if (flush_exc_i) begin
      state_d     = MD_IDLE;
      cnt_d       = '0;
      md_cancel_o = (state_q == MD_RUN);
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (op_v && !to_q) begin
            state_d    = MD_RUN;
            cnt_d      = '0;
            md_start_o = 1'b1;
          end
        end
        MD_RUN: begin
          cnt_d = cnt_q + CW'(1);
          if (md_ready_i) begin
            state_d = MD_DONE;
          end else if (cnt_q == CNT_MAX) begin
            state_d     = MD_IDLE;
            to_d        = 1'b1;
            md_cancel_o = 1'b1;
          end
        end
        MD_DONE: begin
          if (!ext_stall_i) state_d = MD_IDLE;
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  assign md_busy_o    = (state_q != MD_IDLE);
  assign md_timeout_o = to_q;
  assign md_wait_o    = ((state_q == MD_IDLE) && op_v && !to_q)
                      || (state_q == MD_RUN);

endmodule

// File: rtl/hazard_mc_ctrl.sv
// Hazard unit: forwarding, stalls and flushes for the 5-stage pipe.
// Multi-cycle op sequencing lives in md_seq_fsm.
module hazard_mc_ctrl
  import hazard_mc_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int MD_TIMEOUT   = 64,
  parameter int BR_RESOLVE_D = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteE,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              memtoregE,
  input  logic              memtoregM,
  input  logic              branchD,
  input  logic              jrD,
  input  logic              balD,
  input  logic              jumpD,
  input  logic              branch_takenE,
  input  logic [1:0]        hilo_weE,
  input  logic [1:0]        hilo_weM,
  input  logic [1:0]        hilo_weW,
  input  logic [1:0]        mdE,
  input  logic              md_ready,
  input  logic              ext_stall,
  input  logic              flush_exc,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardhiloE,
  output logic              md_start,
  output logic              md_cancel,
  output logic              md_busy,
  output logic              md_timeout
);

  localparam logic RES_D = (BR_RESOLVE_D != 0);

  logic md_wait;
  logic lwstall;
  logic brstall;
  logic stall_e;
  logic stall_fd;
  logic e_hit;
  logic m_hit;

  md_seq_fsm #(
    .MD_TIMEOUT(MD_TIMEOUT)
  ) u_md (
    .clk         (clk),
    .rst         (rst),
    .md_op_i     (mdE),
    .md_ready_i  (md_ready),
    .ext_stall_i (ext_stall),
    .flush_exc_i (flush_exc),
    .md_start_o  (md_start),
    .md_cancel_o (md_cancel),
    .md_busy_o   (md_busy),
    .md_timeout_o(md_timeout),
    .md_wait_o   (md_wait)
  );

  // GPR and HI/LO forward selects; M wins over W, r0 never forwarded.
  always_comb begin
    forwardaE = FWD_RF;
    forwardbE = FWD_RF;
    if (rsE != '0 && regwriteM && writeregM == rsE)
      forwardaE = FWD_M;
    else if (rsE != '0 && regwriteW && writeregW == rsE)
      forwardaE = FWD_W;
    if (rtE != '0 && regwriteM && writeregM == rtE)
      forwardbE = FWD_M;
    else if (rtE != '0 && regwriteW && writeregW == rtE)
      forwardbE = FWD_W;
    forwardaD = RES_D && rsD != '0
             && regwriteM && writeregM == rsD;
    forwardbD = RES_D && rtD != '0
             && regwriteM && writeregM == rtD;
    forwardhiloE = HILO_FWD_NONE;
    if (hilo_weE == 2'b00) begin
      if (hilo_weM != 2'b00)
        forwardhiloE = HILO_FWD_M;
      else if (hilo_weW != 2'b00)
        forwardhiloE = HILO_FWD_W;
    end
  end

  assign e_hit = regwriteE && writeregE != '0
              && (writeregE == rsD || writeregE == rtD);
  assign m_hit = memtoregM
              && (writeregM == rsD || writeregM == rtD);

  // Load-use and branch-operand stalls.
  always_comb begin
    lwstall = memtoregE && e_hit;
    brstall = RES_D
           && (((branchD || jrD || balD) && e_hit)
            || ((branchD || jrD) && m_hit));
  end

  assign stall_e  = md_wait || ext_stall;
  assign stall_fd = lwstall || brstall || stall_e;

  // Stage holds and bubbles; an exception flush drops every stall.
  always_comb begin
    stallE = stall_e && !flush_exc;
    stallM = ext_stall && !flush_exc;
    stallF = stall_fd && !flush_exc;
    stallD = stall_fd && !flush_exc;
    flushE = flush_exc
          || ((lwstall || brstall || jumpD || (branchD && !balD))
              && !stall_e);
    flushM = flush_exc || (md_wait && !ext_stall);
    flushD = flush_exc
          || (!RES_D && branch_takenE && !stall_e);
  end

endmodule
